// File: rtl/axi_lite_sram_slave_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// read/write FSM state encodings, latency counter width and LFSR constants.
package axi_lite_sram_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Latency counters are wide enough for any practical RD/WR_LATENCY plus
    // the optional random extension.
    localparam int CNT_W = 16;

    // Galois LFSR for the optional random-delay mode: x^8+x^6+x^5+x^4+1
    // expressed as a right-shift feedback mask.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    // Response code for a decoded access.
    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_lite_sram_slave_lfsr8.sv
// 8-bit Galois LFSR that supplies pseudo-random delay amounts to the
// responder. Only instantiated when AXI_SRAM_RAND_DELAY_EN is defined.
module axi_lfsr8
    import axi_lite_sram_slave_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [2:0] lat_extra_o,
    output logic [1:0] rearm_extra_o
);

    logic [7:0] lfsr_reg;

    // Advance the LFSR every cycle; shifted-out bit folds back through the taps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 8'h00);
        end
    end

    assign lat_extra_o   = lfsr_reg[2:0];
    assign rearm_extra_o = lfsr_reg[4:3];

    // Bits above the ones used still participate in the sequence.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_reg[7:5];

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder backed by a word-addressed byte-lane memory.
// Read and write channels are independent FSMs so both may be in flight.
// Optional macro AXI_SRAM_RAND_DELAY_EN adds LFSR-driven latency and
// ready re-arm jitter; without it latency is exactly RD/WR_LATENCY.
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          MEM_WORDS  = 4096,
    parameter int          RD_LATENCY = 1,
    parameter int          WR_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] araddr_i,
    input  logic [2:0]  arsize_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    import axi_lite_sram_slave_pkg::*;

    localparam int          IDX_W  = $clog2(MEM_WORDS);
    localparam logic [32:0] BASE33 = {1'b0, BASE_ADDR};
    localparam logic [32:0] SPAN   = 33'(MEM_WORDS) << 2;

    // Size is informational only; a whole word is always returned.
    logic unused_arsize;
    assign unused_arsize = ^arsize_i;

    // ------------------------------------------------------------------
    // Delay sources
    // ------------------------------------------------------------------
    logic [2:0] lat_extra;
    logic [1:0] rearm_extra;

`ifdef AXI_SRAM_RAND_DELAY_EN
    axi_lfsr8 u_lfsr (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .lat_extra_o   (lat_extra),
        .rearm_extra_o (rearm_extra)
    );
`else
    assign lat_extra   = 3'd0;
    assign rearm_extra = 2'd0;
`endif

    // ------------------------------------------------------------------
    // Address decode: 33-bit offset so addresses below BASE wrap to a huge
    // value and fail the range check without a separate comparison.
    // ------------------------------------------------------------------
    logic [32:0]      ar_off;
    logic [32:0]      aw_off;
    logic             ar_in_range;
    logic             aw_in_range;
    logic [IDX_W-1:0] ar_idx;
    logic [IDX_W-1:0] aw_idx;

    assign ar_off      = {1'b0, araddr_i} - BASE33;
    assign aw_off      = {1'b0, awaddr_i} - BASE33;
    assign ar_in_range = (ar_off < SPAN);
    assign aw_in_range = (aw_off < SPAN);
    assign ar_idx      = ar_off[IDX_W+1:2];
    assign aw_idx      = aw_off[IDX_W+1:2];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    r_state_e         r_state_reg;
    logic             arready_reg;
    logic             rvalid_reg;
    logic [31:0]      rdata_reg;
    logic [1:0]       rresp_reg;
    logic [CNT_W-1:0] r_cnt_reg;
    logic [1:0]       r_rearm_reg;
    logic [IDX_W-1:0] r_idx_reg;
    logic             r_in_range_reg;

    w_state_e         w_state_reg;
    logic             awready_reg;
    logic             wready_reg;
    logic             bvalid_reg;
    logic [1:0]       bresp_reg;
    logic             aw_held_reg;
    logic             w_held_reg;
    logic [IDX_W-1:0] w_idx_reg;
    logic             w_in_range_reg;
    logic [31:0]      w_data_reg;
    logic [3:0]       w_strb_reg;
    logic [CNT_W-1:0] w_cnt_reg;
    logic [1:0]       w_rearm_reg;

    logic [31:0]      mem_rd_word;
    logic             mem_we;
    logic             aw_hs;
    logic             w_hs;

    assign aw_hs  = awvalid_i & awready_reg;
    assign w_hs   = wvalid_i & wready_reg;
    assign mem_we = (w_state_reg == W_WAIT) && (w_cnt_reg == '0) && w_in_range_reg;

    // ------------------------------------------------------------------
    // Memory: one byte-wide array per lane so strobes map to lane enables.
    // The read side is captured into rdata_reg by the read FSM; since the
    // write is non-blocking, a same-cycle read of the same word sees the
    // old contents.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [MEM_WORDS];

            // Commit this byte lane when its strobe is set.
            always_ff @(posedge clk_i) begin
                if (mem_we && w_strb_reg[gi]) begin
                    mem_lane[w_idx_reg] <= w_data_reg[gi*8 +: 8];
                end
            end

            assign mem_rd_word[gi*8 +: 8] = mem_lane[r_idx_reg];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read FSM: accept AR, wait out the latency, present R until accepted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_reg    <= R_IDLE;
            arready_reg    <= 1'b0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= 32'h0;
            rresp_reg      <= AXI_RESP_OKAY;
            r_cnt_reg      <= '0;
            r_rearm_reg    <= 2'd0;
            r_idx_reg      <= '0;
            r_in_range_reg <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (!arready_reg) begin
                        // Re-arm after reset or after a jittered R handshake.
                        if (r_rearm_reg == 2'd0) begin
                            arready_reg <= 1'b1;
                        end else begin
                            r_rearm_reg <= r_rearm_reg - 2'd1;
                        end
                    end else if (arvalid_i) begin
                        r_idx_reg      <= ar_idx;
                        r_in_range_reg <= ar_in_range;
                        r_cnt_reg      <= CNT_W'(RD_LATENCY - 1) + CNT_W'(lat_extra);
                        arready_reg    <= 1'b0;
                        r_state_reg    <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_reg == '0) begin
                        rdata_reg   <= r_in_range_reg ? mem_rd_word : 32'h0;
                        rresp_reg   <= resp_for(r_in_range_reg);
                        rvalid_reg  <= 1'b1;
                        r_state_reg <= R_RESP;
                    end else begin
                        r_cnt_reg <= r_cnt_reg - CNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (rready_i) begin
                        rvalid_reg  <= 1'b0;
                        arready_reg <= (rearm_extra == 2'd0);
                        r_rearm_reg <= rearm_extra - 2'd1;
                        r_state_reg <= R_IDLE;
                    end
                end
                default: begin
                    r_state_reg <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: collect AW and W in any order, wait, commit, present B.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_reg    <= W_IDLE;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            bvalid_reg     <= 1'b0;
            bresp_reg      <= AXI_RESP_OKAY;
            aw_held_reg    <= 1'b0;
            w_held_reg     <= 1'b0;
            w_idx_reg      <= '0;
            w_in_range_reg <= 1'b0;
            w_data_reg     <= 32'h0;
            w_strb_reg     <= 4'h0;
            w_cnt_reg      <= '0;
            w_rearm_reg    <= 2'd0;
        end else begin
            case (w_state_reg)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_idx_reg      <= aw_idx;
                        w_in_range_reg <= aw_in_range;
                        aw_held_reg    <= 1'b1;
                        awready_reg    <= 1'b0;
                    end
                    if (w_hs) begin
                        w_data_reg  <= wdata_i;
                        w_strb_reg  <= wstrb_i;
                        w_held_reg  <= 1'b1;
                        wready_reg  <= 1'b0;
                    end
                    if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs)) begin
                        w_cnt_reg   <= CNT_W'(WR_LATENCY - 1) + CNT_W'(lat_extra);
                        w_state_reg <= W_WAIT;
                    end else if (!aw_held_reg && !w_held_reg && !awready_reg && !wready_reg) begin
                        // Re-arm both channels together after reset or a B handshake.
                        if (w_rearm_reg == 2'd0) begin
                            awready_reg <= 1'b1;
                            wready_reg  <= 1'b1;
                        end else begin
                            w_rearm_reg <= w_rearm_reg - 2'd1;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt_reg == '0) begin
                        bresp_reg   <= resp_for(w_in_range_reg);
                        bvalid_reg  <= 1'b1;
                        aw_held_reg <= 1'b0;
                        w_held_reg  <= 1'b0;
                        w_state_reg <= W_RESP;
                    end else begin
                        w_cnt_reg <= w_cnt_reg - CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_reg  <= 1'b0;
                        awready_reg <= (rearm_extra == 2'd0);
                        wready_reg  <= (rearm_extra == 2'd0);
                        w_rearm_reg <= rearm_extra - 2'd1;
                        w_state_reg <= W_IDLE;
                    end
                end
                default: begin
                    w_state_reg <= W_IDLE;
                end
            endcase
        end
    end

    assign arready_o = arready_reg;
    assign rvalid_o  = rvalid_reg;
    assign rdata_o   = rdata_reg;
    assign rresp_o   = rresp_reg;
    assign awready_o = awready_reg;
    assign wready_o  = wready_reg;
    assign bvalid_o  = bvalid_reg;
    assign bresp_o   = bresp_reg;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench for axi_lite_sram_slave (default build, random delay off).
// Table of read/write vectors plus hand-written sequences for W-before-AW,
// R backpressure and reset during a read.
module tb_axi_lite_sram_slave;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          WORDS  = 4096;
    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 1;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] araddr_i;
    logic [2:0]  arsize_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] awaddr_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;

    axi_lite_sram_slave #(
        .BASE_ADDR  (BASE),
        .MEM_WORDS  (WORDS),
        .RD_LATENCY (RD_LAT),
        .WR_LATENCY (WR_LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .araddr_i  (araddr_i),
        .arsize_i  (arsize_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .awaddr_i  (awaddr_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .bresp_o   (bresp_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    localparam int NV = 14;
    vec_t        tbl [NV];
    rexp_t       r_q [$];
    logic [1:0]  b_q [$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait for an R beat, check latency and scoreboard entry, then accept it.
    task automatic wait_r(input string tag);
        int    lat;
        rexp_t e;
        lat = 0;
        while (!rvalid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!rvalid_o) begin
            chk({tag, "_r_timeout"}, 32'(0), 32'(1));
            return;
        end
        chk({tag, "_r_latency"}, 32'(lat), 32'(RD_LAT));
        if (r_q.size() == 0) begin
            chk({tag, "_r_sb_empty"}, 32'(0), 32'(1));
        end else begin
            e = r_q.pop_front();
            chk({tag, "_rdata"}, rdata_o, e.data);
            chk({tag, "_rresp"}, 32'(rresp_o), 32'(e.resp));
        end
        $display("txn %s READ rdata=%h rresp=%0d lat=%0d", tag, rdata_o, rresp_o, lat);
        @(posedge clk_i); #1;
        chk({tag, "_rvalid_clr"}, 32'(rvalid_o), 32'(0));
        chk({tag, "_arready_rearm"}, 32'(arready_o), 32'(1));
    endtask

    task automatic wait_b(input string tag);
        int         lat;
        logic [1:0] e;
        lat = 0;
        while (!bvalid_o && lat < 100) begin
            @(posedge clk_i); #1;
            lat++;
        end
        if (!bvalid_o) begin
            chk({tag, "_b_timeout"}, 32'(0), 32'(1));
            return;
        end
        chk({tag, "_b_latency"}, 32'(lat), 32'(WR_LAT));
        if (b_q.size() == 0) begin
            chk({tag, "_b_sb_empty"}, 32'(0), 32'(1));
        end else begin
            e = b_q.pop_front();
            chk({tag, "_bresp"}, 32'(bresp_o), 32'(e));
        end
        $display("txn %s WRITE bresp=%0d lat=%0d", tag, bresp_o, lat);
        @(posedge clk_i); #1;
        chk({tag, "_bvalid_clr"}, 32'(bvalid_o), 32'(0));
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int    n;
        bit    hs;
        rexp_t e;
        araddr_i  = addr;
        arvalid_i = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            hs = arready_o;
            @(posedge clk_i); #1;
            n++;
        end
        arvalid_i = 1'b0;
        if (!hs) begin
            chk({tag, "_ar_timeout"}, 32'(0), 32'(1));
            return;
        end
        e.data = exp_data;
        e.resp = exp_resp;
        r_q.push_back(e);
        wait_r(tag);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        awaddr_i  = addr;
        wdata_i   = data;
        wstrb_i   = strb;
        awvalid_i = 1'b1;
        wvalid_i  = 1'b1;
        n = 0; aw_done = 1'b0; w_done = 1'b0;
        while (!(aw_done && w_done) && n < 100) begin
            aw_hs = awvalid_i && awready_o;
            w_hs  = wvalid_i && wready_o;
            @(posedge clk_i); #1;
            n++;
            if (aw_hs) begin aw_done = 1'b1; awvalid_i = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid_i  = 1'b0; end
        end
        awvalid_i = 1'b0;
        wvalid_i  = 1'b0;
        if (!(aw_done && w_done)) begin
            chk({tag, "_aw_w_timeout"}, 32'(0), 32'(1));
            return;
        end
        b_q.push_back(exp_resp);
        wait_b(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  hs;
        rexp_t e;

        tbl[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        tbl[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        tbl[2]  = '{1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        tbl[3]  = '{1'b1, 32'h8000_0020, 32'h00AB_0000, 4'h4, 32'h0,         2'b00};
        tbl[4]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11AB_3344, 2'b00};
        tbl[5]  = '{1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
        tbl[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'h0, 32'h11AB_3344, 2'b00};
        tbl[7]  = '{1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0,         2'b00};
        tbl[8]  = '{1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 32'h0,         2'b10};
        tbl[9]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 2'b00};
        tbl[10] = '{1'b0, 32'h8000_4000, 32'h0,         4'h0, 32'h0,         2'b10};
        tbl[11] = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};
        tbl[12] = '{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b00};
        tbl[13] = '{1'b0, 32'h8000_3FFF, 32'h0,         4'h0, 32'hCAFE_F00D, 2'b00};

        rst_i     = 1'b1;
        araddr_i  = '0;
        arsize_i  = 3'd2;
        arvalid_i = 1'b0;
        rready_i  = 1'b1;
        awaddr_i  = '0;
        awvalid_i = 1'b0;
        wdata_i   = '0;
        wstrb_i   = '0;
        wvalid_i  = 1'b0;
        bready_i  = 1'b1;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_arready", 32'(arready_o), 32'(0));
        chk("rst_rvalid",  32'(rvalid_o),  32'(0));
        chk("rst_awready", 32'(awready_o), 32'(0));
        chk("rst_wready",  32'(wready_o),  32'(0));
        chk("rst_bvalid",  32'(bvalid_o),  32'(0));
        chk("rst_rdata",   rdata_o,        32'h0);
        chk("rst_rresp",   32'(rresp_o),   32'(0));
        chk("rst_bresp",   32'(bresp_o),   32'(0));
        rst_i = 1'b0;
        #1;
        chk("pre_edge_arready", 32'(arready_o), 32'(0));
        @(posedge clk_i); #1;
        chk("arm_arready", 32'(arready_o), 32'(1));
        chk("arm_awready", 32'(awready_o), 32'(1));
        chk("arm_wready",  32'(wready_o),  32'(1));

        // Table-driven transactions
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            if (tbl[i].wr) begin
                do_write(tag, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].exp_resp);
            end else begin
                do_read(tag, tbl[i].addr, tbl[i].exp_rdata, tbl[i].exp_resp);
            end
        end

        // W arrives three cycles before AW
        wdata_i  = 32'h5A5A_0F0F;
        wstrb_i  = 4'hF;
        wvalid_i = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            hs = wready_o;
            @(posedge clk_i); #1;
            n++;
        end
        wvalid_i = 1'b0;
        chk("wfirst_w_hs", 32'(hs), 32'(1));
        chk("wfirst_wready_drop", 32'(wready_o), 32'(0));
        chk("wfirst_awready_held", 32'(awready_o), 32'(1));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            chk($sformatf("wfirst_no_bvalid%0d", c), 32'(bvalid_o), 32'(0));
        end
        awaddr_i  = 32'h8000_0040;
        awvalid_i = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            hs = awready_o;
            @(posedge clk_i); #1;
            n++;
        end
        awvalid_i = 1'b0;
        chk("wfirst_aw_hs", 32'(hs), 32'(1));
        b_q.push_back(2'b00);
        wait_b("wfirst");
        do_read("wfirst_rb", 32'h8000_0040, 32'h5A5A_0F0F, 2'b00);

        // R backpressure for five cycles
        rready_i  = 1'b0;
        araddr_i  = 32'h8000_0010;
        arvalid_i = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            hs = arready_o;
            @(posedge clk_i); #1;
            n++;
        end
        arvalid_i = 1'b0;
        e.data = 32'hDEAD_BEEF;
        e.resp = 2'b00;
        r_q.push_back(e);
        n = 0;
        while (!rvalid_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("bp_rvalid_seen", 32'(rvalid_o), 32'(1));
        e = r_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            chk($sformatf("bp_rvalid%0d", c),  32'(rvalid_o),  32'(1));
            chk($sformatf("bp_rdata%0d", c),   rdata_o,        e.data);
            chk($sformatf("bp_rresp%0d", c),   32'(rresp_o),   32'(e.resp));
            chk($sformatf("bp_arready%0d", c), 32'(arready_o), 32'(0));
        end
        $display("txn bp READ rdata=%h rresp=%0d held=5", rdata_o, rresp_o);
        rready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp_rvalid_clr",  32'(rvalid_o),  32'(0));
        chk("bp_arready_set", 32'(arready_o), 32'(1));

        // Reset asserted between edges while the read FSM is waiting
        araddr_i  = 32'h8000_0020;
        arvalid_i = 1'b1;
        n = 0; hs = 1'b0;
        while (!hs && n < 100) begin
            hs = arready_o;
            @(posedge clk_i); #1;
            n++;
        end
        arvalid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("mrst_rvalid",  32'(rvalid_o),  32'(0));
        chk("mrst_arready", 32'(arready_o), 32'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("mrst_arready_rearm", 32'(arready_o), 32'(1));
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("mrst_no_stale%0d", c), 32'(rvalid_o), 32'(0));
            @(posedge clk_i); #1;
        end
        $display("txn mrst RESET aborted read arready=%0d", arready_o);
        do_read("post_rst", 32'h8000_0020, 32'h11AB_3344, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_lite_sram_slave.md
Name: axi_lite_sram_slave

Overview:
- AXI4-Lite responder (slave) for the LSU-side master: accepts AR/AW/W requests, returns R and B responses.
- Backed by an internal word-addressed memory array with configurable access latency.
- Sits between the core's memory-request ports and simulation/FPGA memory.
- Read and write channels run as independent FSMs so both can be in flight at once.

Parameters:
- BASE_ADDR, 32'h8000_0000: byte address mapped to word 0.
- MEM_WORDS, 4096: number of 32-bit words; must be a power of two.
- RD_LATENCY, 1: cycles from AR handshake to rvalid_o; must be ≥1.
- WR_LATENCY, 1: cycles from the second of the AW/W handshakes to bvalid_o; must be ≥1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- araddr_i  in  32  read byte address.
- arsize_i  in  3  read size (0=byte, 1=half, 2=word); informational only, full word always returned.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address ready.
- rdata_o  out  32  read data: whole aligned word.
- rresp_o  out  2  read response.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data ready.
- awaddr_i  in  32  write byte address.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address ready.
- wdata_i  in  32  write data, lane-aligned.
- wstrb_i  in  4  byte enables.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data ready.
- bresp_o  out  2  write response.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response ready.

Behaviour:
- Reset (rst_i high, async):
  - All outputs 0: arready_o, rvalid_o, awready_o, wready_o, bvalid_o, rdata_o, rresp_o, bresp_o.
  - Both FSMs go to IDLE; the memory array is not cleared.
- Ready signals are registered. The first rising edge after rst_i deasserts sets arready_o, awready_o and wready_o to 1.
- Address decode:
  - idx = (addr − BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff BASE_ADDR ≤ addr < BASE_ADDR + 4*MEM_WORDS.
  - Out of range → resp SLVERR (2'b10), rdata 0, no write. Otherwise OKAY (2'b00).
- Read FSM, states R_IDLE → R_WAIT → R_RESP:
  - R_IDLE, arready_o=1: on arvalid_i & arready_o, latch address, load counter = RD_LATENCY−1, drop arready_o.
  - R_WAIT: decrement counter each cycle; at 0, sample mem[idx], assert rvalid_o, go to R_RESP. With RD_LATENCY=1, rvalid_o is high the cycle after the AR handshake.
  - R_RESP: hold rvalid_o/rdata_o/rresp_o stable until rready_i. On the handshake, rvalid_o←0, arready_o←1, go to R_IDLE.
  - No back-to-back AR acceptance in the handshake cycle.
- Write FSM, states W_IDLE → W_WAIT → W_RESP:
  - W_IDLE collects AW and W independently; each ready drops the cycle after its own handshake.
  - AW-first, W-first and same-cycle arrival are all legal.
  - When both are held, load counter = WR_LATENCY−1 and enter W_WAIT.
  - W_WAIT: at counter 0, commit bytes where wstrb_i bit=1 (in range only), assert bvalid_o, go to W_RESP.
  - W_RESP: hold bvalid_o/bresp_o until bready_i. Then re-raise awready_o and wready_o and return to W_IDLE.
  - wstrb=0 → OKAY, memory unchanged.
- Same-word read sample and write commit in the same cycle: read returns the old data (read-before-write).
- Reset mid-transaction aborts both FSMs silently; any partially collected AW/W is discarded.

Optional Feature:
- Macro AXI_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Galois LFSR (taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every cycle.
  - Each transaction adds LFSR[2:0] extra cycles (0–7) to its latency counter at load.
  - arready_o, awready_o and wready_o each stay 0 for LFSR[4:3] extra cycles after re-arming.
- Undefined: latency exactly RD_LATENCY/WR_LATENCY; no LFSR logic instantiated.

Decomposition:
- Shared header riscv_param.vh gets:
  - AXI_RESP_OKAY 2'b00 and AXI_RESP_SLVERR 2'b10.
  - Read/write FSM state encodings (2 bits each).
- One sub-module, axi_lfsr8: the LFSR, instantiated only under AXI_SRAM_RAND_DELAY_EN.

Test Plan:
- Word write then read, macro undefined:
  - Stimulus: AW 0x8000_0010 and W 0xDEADBEEF/strb 4'hF in the same cycle, bready=1; then AR 0x8000_0010, rready=1.
  - Response: bvalid one cycle after the handshake, bresp 0; rvalid one cycle after AR, rdata 0xDEADBEEF, rresp 0.
- Byte strobes:
  - Stimulus: preload 0x11223344; write 0x00AB0000 with strb 4'b0100.
  - Response: readback 0x11AB3344.
- W before AW:
  - Stimulus: W valid 3 cycles before AW.
  - Response: wready drops after the W handshake; bvalid exactly WR_LATENCY cycles after the AW handshake; data committed.
- Backpressure:
  - Stimulus: rready=0 for 5 cycles.
  - Response: rvalid, rdata and rresp stable for all 5 cycles; arready stays 0 until the cycle after the R handshake.
- Out of range:
  - Stimulus: AR 0x7FFF_FFFC, and a write to BASE+4*MEM_WORDS.
  - Response: rresp 2'b10 with rdata 0; bresp 2'b10 with memory unchanged.
- Reset mid-transaction:
  - Stimulus: assert rst_i between clock edges while in R_WAIT.
  - Response: rvalid and arready go to 0 immediately; after release, arready=1 on the first edge and no stale R beat is issued.
